wishbone_burst_master: RTL and testbench

//  Parametrised successor to the single-width packet master. Turns a packet request (address, length, payload) into a

---
 rtl/wishbone_burst_master.sv | 215 +++++++++++++++++++++
 tb/tb_wishbone_burst_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 registered-feedback burst master: packet request in, CTI-tagged burst out, with per-beat timeout.
// Define WB_MASTER_ERR_EN to add the err_i port and bus-error abort; left undefined, error stays 0.
module wishbone_burst_master #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = DATA_WIDTH / 8,
    parameter int MAX_WAIT      = 8,
    parameter int MAX_PAYLOAD   = 8,
    parameter int PW            = MAX_PAYLOAD * DATA_WIDTH,
    parameter int LN            = $clog2(MAX_PAYLOAD) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic [ADDRESS_WIDTH-1:0] adr_o,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    output logic                     we_o,
    output logic [DATA_BYTES-1:0]    sel_o,
    output logic                     stb_o,
    input  logic                     cyc_i,
    output logic                     cyc_o,
    input  logic                     ack_i,
`ifdef WB_MASTER_ERR_EN
    input  logic                     err_i,
`endif
    output logic [2:0]               cti_o,
    input  logic [ADDRESS_WIDTH-1:0] transfer_address,
    input  logic                     addr_fixed,
    input  logic [PW-1:0]            payload_in,
    output logic [PW-1:0]            payload_out,
    input  logic [LN-1:0]            payload_length,
    input  logic                     start_read,
    output logic                     read_busy,
    input  logic                     start_write,
    output logic                     write_busy,
    output logic [LN-1:0]            beats_done,
    output logic                     completed,
    output logic                     timeout,
    output logic                     error
);

    // state  | meaning
    // S_IDLE | no packet; accepts start_read / start_write
    // S_ARB  | packet latched, waiting for cyc_i to fall
    // S_BEAT | cyc_o/stb_o high, one beat on the bus
    typedef enum logic [1:0] {S_IDLE, S_ARB, S_BEAT} state_t;

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic                     we_q;
    logic [DATA_BYTES-1:0]    sel_q;
    logic                     stb_q;
    logic                     cyc_q;
    logic [2:0]               cti_q;
    logic [PW-1:0]            pout_q;
    logic [PW-1:0]            wdata_q;
    logic                     rbusy_q;
    logic                     wbusy_q;
    logic [LN-1:0]            beats_q;
    logic [LN-1:0]            len_q;
    logic                     fixed_q;
    logic [WW-1:0]            wait_q;
    logic                     completed_q;
    logic                     timeout_q;
    logic                     error_q;
    logic [LN-1:0]            len_d;
    logic [LN-1:0]            beat_nxt_d;
    logic                     bus_err;

`ifdef WB_MASTER_ERR_EN
    assign bus_err = err_i;
`else
    assign bus_err = 1'b0;
`endif

    // Oversized requests are clamped so the payload slot index stays inside PW.
    always_comb begin
        len_d = payload_length;
        if (payload_length > LN'(MAX_PAYLOAD)) len_d = LN'(MAX_PAYLOAD);
    end

    assign beat_nxt_d = beats_q + LN'(1);

    function automatic logic [2:0] cti_for(input logic [LN-1:0] idx,
                                           input logic [LN-1:0] len,
                                           input logic          fixed);
        if (len == LN'(1))             return 3'b000;
        else if (idx == len - LN'(1))  return 3'b111;
        else if (fixed)                return 3'b001;
        else                           return 3'b010;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            stb_q       <= 1'b0;
            cyc_q       <= 1'b0;
            cti_q       <= 3'b000;
            pout_q      <= '0;
            wdata_q     <= '0;
            rbusy_q     <= 1'b0;
            wbusy_q     <= 1'b0;
            beats_q     <= '0;
            len_q       <= '0;
            fixed_q     <= 1'b0;
            wait_q      <= '0;
            completed_q <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            completed_q <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_read || start_write) begin
                        adr_q   <= transfer_address;
                        fixed_q <= addr_fixed;
                        len_q   <= len_d;
                        beats_q <= '0;
                        wait_q  <= '0;
                        dat_q   <= payload_in[DATA_WIDTH-1:0];
                        wdata_q <= payload_in >> DATA_WIDTH;
                        if (len_d == '0) begin
                            completed_q <= 1'b1;
                        end else begin
                            rbusy_q <= start_read;
                            wbusy_q <= !start_read;
                            state_q <= S_ARB;
                        end
                    end
                end
                S_ARB: begin
                    if (!cyc_i) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= wbusy_q;
                        sel_q   <= '1;
                        cti_q   <= cti_for('0, len_q, fixed_q);
                        state_q <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (bus_err) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                        cti_q   <= 3'b000;
                        rbusy_q <= 1'b0;
                        wbusy_q <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (ack_i) begin
                        beats_q <= beat_nxt_d;
                        wait_q  <= '0;
                        if (rbusy_q) pout_q[int'(beats_q)*DATA_WIDTH +: DATA_WIDTH] <= dat_i;
                        if (beat_nxt_d == len_q) begin
                            cyc_q       <= 1'b0;
                            stb_q       <= 1'b0;
                            we_q        <= 1'b0;
                            sel_q       <= '0;
                            cti_q       <= 3'b000;
                            rbusy_q     <= 1'b0;
                            wbusy_q     <= 1'b0;
                            completed_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            if (!fixed_q) adr_q <= adr_q + ADDRESS_WIDTH'(1);
                            dat_q   <= wdata_q[DATA_WIDTH-1:0];
                            wdata_q <= wdata_q >> DATA_WIDTH;
                            cti_q   <= cti_for(beat_nxt_d, len_q, fixed_q);
                        end
                    end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= '0;
                        cti_q     <= 3'b000;
                        rbusy_q   <= 1'b0;
                        wbusy_q   <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign stb_o       = stb_q;
    assign cyc_o       = cyc_q;
    assign cti_o       = cti_q;
    assign payload_out = pout_q;
    assign read_busy   = rbusy_q;
    assign write_busy  = wbusy_q;
    assign beats_done  = beats_q;
    assign completed   = completed_q;
    assign timeout     = timeout_q;
    assign error       = error_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Testbench for wishbone_burst_master: directed packet table, random packets, reset and arbitration corners.
module tb_wishbone_burst_master;
    localparam int AW = 16, DW = 8, MW = 8, MP = 8, PW = 64, LN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_i = '0;
    logic [DW-1:0] dat_o;
    logic          we_o;
    logic [0:0]    sel_o;
    logic          stb_o;
    logic          cyc_i = 1'b0;
    logic          cyc_o;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic [2:0]    cti_o;
    logic [AW-1:0] transfer_address = '0;
    logic          addr_fixed = 1'b0;
    logic [PW-1:0] payload_in = '0;
    logic [PW-1:0] payload_out;
    logic [LN-1:0] payload_length = '0;
    logic          start_read = 1'b0;
    logic          read_busy;
    logic          start_write = 1'b0;
    logic          write_busy;
    logic [LN-1:0] beats_done;
    logic          completed;
    logic          timeout;
    logic          error;

    wishbone_burst_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(1), .MAX_WAIT(MW), .MAX_PAYLOAD(MP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .adr_o(adr_o), .dat_i(dat_i), .dat_o(dat_o), .we_o(we_o),
        .sel_o(sel_o), .stb_o(stb_o), .cyc_i(cyc_i), .cyc_o(cyc_o), .ack_i(ack_i),
`ifdef WB_MASTER_ERR_EN
        .err_i(err_i),
`endif
        .cti_o(cti_o), .transfer_address(transfer_address), .addr_fixed(addr_fixed),
        .payload_in(payload_in), .payload_out(payload_out), .payload_length(payload_length),
        .start_read(start_read), .read_busy(read_busy), .start_write(start_write),
        .write_busy(write_busy), .beats_done(beats_done), .completed(completed),
        .timeout(timeout), .error(error)
    );

    // exp_end: 0 completed, 1 timeout, 2 bus error
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        fixed;
        logic [3:0]  len;
        logic [63:0] payload;
        logic [7:0]  salt;
        logic [7:0]  hold;
        logic [31:0] delays;
        logic [3:0]  err_beat;
        logic        poke;
        logic [3:0]  exp_beats;
        logic [1:0]  exp_end;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] model_pout = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {adr_o, dat_o, we_o, sel_o, stb_o, cyc_o, cti_o, payload_out,
                read_busy, write_busy, beats_done, completed, timeout, error};
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic fixed, input logic [3:0] len, input logic [63:0] payload,
                                input logic [7:0] salt, input logic [7:0] hold, input logic [31:0] delays,
                                input logic poke, input logic [3:0] exp_beats, input logic [1:0] exp_end);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.fixed = fixed; v.len = len; v.payload = payload;
        v.salt = salt; v.hold = hold; v.delays = delays; v.err_beat = 4'hF; v.poke = poke;
        v.exp_beats = exp_beats; v.exp_end = exp_end;
        return v;
    endfunction

    // Outcome from the packet rules: first erring beat, else first beat whose ack never arrives within MW cycles.
    function automatic void model_outcome(input vec_t v, output logic [3:0] eb, output logic [1:0] kind);
        eb = v.len; kind = 2'd0;
        for (int i = 0; i < int'(v.len); i++) begin
            if (i == int'(v.err_beat)) begin eb = 4'(i); kind = 2'd2; break; end
            if (int'(v.delays[i*4 +: 4]) >= MW) begin eb = 4'(i); kind = 2'd1; break; end
        end
    endfunction

    function automatic logic [15:0] beat_addr(input vec_t v, input int k);
        return v.addr + (v.fixed ? 16'd0 : 16'(k));
    endfunction

    function automatic logic [7:0] rd_byte(input vec_t v, input int k);
        logic [15:0] a;
        a = beat_addr(v, k) + 16'h0010;
        return a[7:0] ^ v.salt;
    endfunction

    function automatic logic [2:0] exp_cti(input vec_t v, input int k);
        if (v.len == 4'd1)          return 3'b000;
        if (k == int'(v.len) - 1)   return 3'b111;
        return v.fixed ? 3'b001 : 3'b010;
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int   k, w, first_stb, exp_first;
        bit   started, ended, arb_ok, rd;
        logic [3:0] d;
        rd = v.rd;
        @(negedge clk);
        transfer_address = v.addr; addr_fixed = v.fixed; payload_length = v.len;
        payload_in = v.payload; start_read = v.rd; start_write = v.wr; cyc_i = (v.hold > 0);
        started = 0; ended = 0; arb_ok = 1; k = 0; w = 0; first_stb = -1;
        exp_first = ((v.hold > 1) ? int'(v.hold) : 1) + 1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            start_read = 0; start_write = (v.poke && c == 2); cyc_i = (c < int'(v.hold));
            ack_i = 0; err_i = 0; dat_i = 8'($urandom);
            if (v.len == 0) begin ended = 1; break; end
            if (stb_o) begin
                if (!started) begin started = 1; first_stb = c; end
                if (w == 0)
                    check({name, "_beat"}, {cyc_o, we_o, sel_o, adr_o, cti_o, (rd ? 8'h00 : dat_o)},
                          {1'b1, !rd, 1'b1, beat_addr(v, k), exp_cti(v, k),
                           (rd ? 8'h00 : v.payload[(k%8)*8 +: 8])});
                d = (k < 8) ? v.delays[k*4 +: 4] : 4'hF;
                if (k == int'(v.err_beat) && w == 0) begin
                    err_i = 1; ack_i = 1;
                end else if (w == int'(d)) begin
                    ack_i = 1; dat_i = rd_byte(v, k);
                end
                if (ack_i && !err_i) begin k++; w = 0; end
                else w++;
            end else if (started) begin
                ended = 1; break;
            end else if (read_busy !== rd || write_busy !== !rd || cyc_o !== 1'b0) begin
                arb_ok = 0;
            end
        end
        ack_i = 0; err_i = 0;
        if (!ended) check({name, "_bounded"}, 1'b0, 1'b1);
        if (v.len != 0) begin
            check({name, "_arb"}, {arb_ok, 8'(first_stb)}, {1'b1, 8'(exp_first)});
        end
        check({name, "_end"}, {cyc_o, stb_o, read_busy, write_busy, completed, timeout, error, beats_done},
              {4'b0000, v.exp_end == 2'd0, v.exp_end == 2'd1, v.exp_end == 2'd2, v.exp_beats});
        if (rd) for (int i = 0; i < int'(v.exp_beats); i++) model_pout[i*8 +: 8] = rd_byte(v, i);
        check({name, "_payload_out"}, payload_out, model_pout);
        @(negedge clk);
        check({name, "_pulse_clear"}, {cyc_o, completed, timeout, error, read_busy, write_busy}, 6'b0);
    endtask

    vec_t tbl[10];
    vec_t v;
    logic [3:0] eb;
    logic [1:0] kind;

    initial begin
        tbl[0] = mk(1, 0, 16'h0012, 0, 4, 64'h0, 8'h00, 0, 32'h0000_2000, 0, 4, 0);  // test 1
        tbl[1] = mk(0, 1, 16'h0012, 1, 4, 64'h0403_0201, 8'h00, 0, 32'h0, 0, 4, 0); // fixed write
        tbl[2] = mk(1, 0, 16'h00FF, 0, 2, 64'h0, 8'h5A, 30, 32'h0000_0001, 1, 2, 0); // held bus + ignored start
        tbl[3] = mk(1, 0, 16'h0200, 0, 4, 64'h0, 8'h33, 0, 32'h0000_0800, 0, 2, 1);  // timeout after 2 acks
        tbl[4] = mk(0, 1, 16'h0300, 0, 0, 64'hFF, 8'h00, 0, 32'h0, 0, 0, 0);         // zero length
        tbl[5] = mk(0, 1, 16'hFFFF, 0, 1, 64'hA5, 8'h00, 0, 32'h0, 0, 1, 0);         // single beat
        tbl[6] = mk(1, 0, 16'hFFFE, 0, 8, 64'h0, 8'hC3, 0, 32'h7777_7777, 0, 8, 0);  // ack on limit, wrap
        tbl[7] = mk(1, 1, 16'h4000, 0, 3, 64'h0, 8'h11, 2, 32'h0000_0102, 0, 3, 0);  // read wins
        tbl[8] = mk(0, 1, 16'h5000, 1, 3, 64'h00CC_BBAA, 8'h00, 0, 32'h0000_000F, 0, 0, 1);
        tbl[9] = mk(0, 1, 16'h6000, 0, 8, 64'h8877_6655_4433_2211, 8'h00, 1, 32'h0123_4567, 0, 8, 0);

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'h0);
        rst_i = 0;

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
            if (i == 0) check("t1_payload", payload_out, 64'h0000_0000_2524_2322);
        end

`ifdef WB_MASTER_ERR_EN
        v = mk(1, 0, 16'h0700, 0, 4, 64'h0, 8'h00, 0, 32'h0, 0, 1, 2);
        v.err_beat = 4'd1;
        run_vec("err_beat1", v);
`endif

        for (int n = 0; n < 40; n++) begin
            v.rd = 1'($urandom_range(0, 1));
            v.wr = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            v.fixed = 1'($urandom_range(0, 1));
            v.len = 4'($urandom_range(0, 8));
            v.payload = {$urandom, $urandom};
            v.salt = 8'($urandom);
            v.hold = 8'($urandom_range(0, 5));
            for (int b = 0; b < 8; b++)
                v.delays[b*4 +: 4] = ($urandom_range(0, 19) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                                   : 4'($urandom_range(0, 7));
            v.err_beat = 4'hF;
`ifdef WB_MASTER_ERR_EN
            if ($urandom_range(0, 4) == 0) v.err_beat = 4'($urandom_range(0, 7));
`endif
            v.poke = 1'($urandom_range(0, 1));
            model_outcome(v, eb, kind);
            v.exp_beats = eb; v.exp_end = kind;
            run_vec($sformatf("rnd%0d", n), v);
        end

        // Reset in the middle of a burst releases the bus and discards the request.
        @(negedge clk);
        transfer_address = 16'h0100; addr_fixed = 0; payload_length = 4'd8; start_read = 1; cyc_i = 0;
        @(negedge clk);
        start_read = 0;
        for (int c = 0; c < 20 && !stb_o; c++) @(negedge clk);
        check("rst_burst_started", stb_o, 1'b1);
        repeat (3) begin ack_i = 1; dat_i = 8'($urandom); @(negedge clk); end
        ack_i = 0; rst_i = 1;
        @(negedge clk);
        check("rst_mid_burst", all_outs(), 128'h0);
        rst_i = 0; model_pout = '0;
        repeat (5) @(negedge clk);
        check("rst_discarded", {cyc_o, read_busy, write_busy, beats_done}, 7'b0);

        run_vec("after_rst", tbl[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
